// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory read handshake
// and feeds the IF/ID register, with a one-entry skid buffer for stalled responses.
module fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] if_id_instr,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic                 if_id_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   pending_q, pending_d;
    logic [WORD_SIZE-1:0]   holdInstr_q, holdInstr_d;
    logic [WORD_SIZE-1:0]   holdPc_q, holdPc_d;
    logic [WORD_SIZE-1:0]   ifInstr_q, ifInstr_d;
    logic [WORD_SIZE-1:0]   ifPc_q, ifPc_d;
    logic                   ifValid_q, ifValid_d;

    logic                   loadValid;
    logic [WORD_SIZE-1:0]   loadInstr;
    logic [WORD_SIZE-1:0]   loadPc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pending_q   <= '0;
            holdInstr_q <= '0;
            holdPc_q    <= '0;
            ifInstr_q   <= '0;
            ifPc_q      <= '0;
            ifValid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
            ifInstr_q   <= ifInstr_d;
            ifPc_q      <= ifPc_d;
            ifValid_q   <= ifValid_d;
        end
    end

    // A redirect without a response parks its target in DRAIN so the address stays put.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pending_d   = pending_q;
        holdInstr_d = holdInstr_q;
        holdPc_d    = holdPc_q;
        loadValid   = 1'b0;
        loadInstr   = holdInstr_q;
        loadPc      = holdPc_q;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect) begin
                    if (i_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        pending_d = redirect_pc;
                        state_d   = DRAIN;
                    end
                end else if (i_ready) begin
                    pc_d = pc_q + WORD_SIZE'(1);
                    if (!stall || !ifValid_q) begin
                        loadValid = 1'b1;
                        loadInstr = i_data;
                        loadPc    = pc_q;
                    end else begin
                        holdInstr_d = i_data;
                        holdPc_d    = pc_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    loadValid = 1'b1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pending_d = redirect_pc;
                end
                if (i_ready) begin
                    pc_d    = redirect ? redirect_pc : pending_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Squash beats hold, hold beats load, and anything else is a bubble.
    always_comb begin
        ifInstr_d = ifInstr_q;
        ifPc_d    = ifPc_q;
        ifValid_d = 1'b0;
        if (redirect || flush) begin
            ifValid_d = 1'b0;
        end else if (stall && ifValid_q) begin
            ifValid_d = 1'b1;
        end else if (loadValid) begin
            ifValid_d = 1'b1;
            ifInstr_d = loadInstr;
            ifPc_d    = loadPc;
        end
    end

    assign i_readM     = (state_q == FETCH) || (state_q == DRAIN);
    assign i_address   = pc_q;
    assign if_id_instr = ifInstr_q;
    assign if_id_pc    = ifPc_q;
    assign if_id_valid = ifValid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It owns the PC and runs the instruction-memory read handshake. It latches each fetched word, together with the word's own address, into the IF/ID register. The decode stage reads that register, and the decode-stage immediate generator consumes the latched instruction. Stall and flush come from the hazard unit. Redirects come from branch/jump resolution.

## Interface
Parameters:
- WORD_SIZE, 16, instruction/address width
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- i_readM  output  1  instruction-memory read request
- i_address  output  WORD_SIZE  request address; stable while i_readM=1 until i_ready
- i_data  input  WORD_SIZE  instruction word; valid when i_ready=1
- i_ready  input  1  one-cycle response strobe; may occur in the first request cycle
- stall  input  1  decode cannot accept; hold IF/ID
- flush  input  1  squash IF/ID contents
- redirect  input  1  load new PC; implies squash of IF/ID and any buffered word
- redirect_pc  input  WORD_SIZE  redirect target
- if_id_instr  output  WORD_SIZE  latched instruction
- if_id_pc  output  WORD_SIZE  address of latched instruction
- if_id_valid  output  1  IF/ID holds a live instruction

## Operation
- Registers:
  - pc: address of the current/next request.
  - pending_pc: redirect target held during DRAIN.
  - hold_buf: one-entry skid buffer holding an instruction word and its address.
  - IF/ID register.
  - state.
- States:
  - IDLE: i_readM=0. Always goes to FETCH on the next edge.
  - FETCH: i_readM=1, i_address=pc.
    - i_ready & redirect: discard i_data; pc<=redirect_pc; stay in FETCH.
    - redirect without i_ready: pending_pc<=redirect_pc; go to DRAIN. pc is unchanged, so the address stays stable.
    - i_ready & IF/ID can accept (stall=0 or if_id_valid=0): IF/ID<={i_data, pc, valid=1}; pc<=pc+1; stay in FETCH.
    - i_ready & stall & if_id_valid: hold_buf<={i_data, pc}; pc<=pc+1; go to HOLD.
  - HOLD: i_readM=0.
    - redirect: drop hold_buf; pc<=redirect_pc; go to FETCH.
    - stall=0: IF/ID<=hold_buf, valid=1; go to FETCH.
  - DRAIN: i_readM=1, i_address=pc (the old address).
    - A redirect updates pending_pc (the last redirect wins).
    - On i_ready: discard i_data; pc<=pending_pc, or redirect_pc if redirect is also asserted that cycle; go to FETCH.
- IF/ID update priority each edge:
  1. redirect or flush clears if_id_valid. if_id_instr and if_id_pc are don't-care and keep their values. Flush beats stall.
  2. Otherwise, stall with if_id_valid=1 holds IF/ID.
  3. Otherwise, load per the state rules above.
  4. Otherwise, if_id_valid<=0 (bubble).
- Address arithmetic: pc+1 is modulo 2^WORD_SIZE. 16'hFFFF wraps to 16'h0000.
- Fetched data is never written to IF/ID while redirect is asserted or while in DRAIN.

## Timing
- Reset (async, while reset_n=0):
  - state=IDLE, pc=RESET_PC, pending_pc=0, hold_buf=0.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0.
  - i_readM=0, i_address=RESET_PC.
- After reset_n rises: first edge gives IDLE→FETCH, and i_readM=1 from that cycle.
- Latency: a word returned with i_ready in cycle N appears on the IF/ID outputs in cycle N+1.
- With zero-wait memory (i_ready every cycle) throughput is one instruction per cycle.
- After a redirect in FETCH with a same-cycle i_ready, the target is requested in the next cycle.
- An outstanding request is never abandoned. i_address never changes while i_readM=1 and i_ready=0.
- Reset mid-request abandons the request immediately. The memory model must tolerate that.

## Test plan
- Reset:
  - Hold reset_n=0 for 3 cycles → i_readM=0, if_id_valid=0.
  - Release → i_readM=1 and i_address=0000 from the first post-reset edge.
- Zero-wait streaming:
  - Memory returns 1000+addr every cycle → if_id_instr=1000,1001,1002 with if_id_pc=0,1,2 in consecutive cycles; if_id_valid=1 throughout.
- Stall with response:
  - IF/ID holds addr 3; stall=1; i_ready returns 5004 for addr 4.
  - → state HOLD, i_readM=0, IF/ID still shows addr 3.
  - Drop stall → next cycle if_id_pc=4, if_id_instr=5004; following request address=5.
- Redirect during a 3-cycle-latency request:
  - redirect to 0040 one cycle after the request to 0007 is issued.
  - → i_address stays 0007 until i_ready; that data is discarded; if_id_valid=0.
  - Next request address=0040.
- Simultaneous events:
  - flush and stall together with if_id_valid=1 → if_id_valid=0 next cycle.
  - redirect to 0020 in the same cycle as i_ready → data dropped; next i_address=0020.
- Wrap-around:
  - redirect to FFFF; zero-wait memory → if_id_pc=FFFF, then 0000.
